rot_req_queue: RTL and testbench

- Request queue sitting directly upstream of the 8-bit rotate-right barrel shifter.
- Accepts (data, rotate-amount) pairs over a valid/ready handshake and buffers up to DEPTH of them.
- Presents the oldest pair on out_a/out_amt, which wire straight to the shifter's a/amt inputs. The consumer pops with out_ready.
- Decouples bursty producers from the consumer of rotated bytes.

---
 rtl/rot_pkg.sv | 15 +
 rtl/rot_req_mem.sv | 34 +++
 rtl/rot_req_queue.sv | 113 +++++++++++
 tb/tb_rot_req_queue.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// rot_pkg: shared widths and the request record for the rotate-request queue.
//   DATA_W    : data width, matches the barrel shifter input width
//   AMT_W     : rotate-amount width, log2(DATA_W)
//   rot_req_t : packed {data, amt} record as stored in the queue
package rot_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
  } rot_req_t;

endpackage

// File: rtl/rot_req_mem.sv
// rot_req_mem: DEPTH x rot_req_t register array, one write port, asynchronous
// read. Contents are deliberately not reset.
// Ports:
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : request written at i_waddr on the rising edge
//   i_raddr : read address
//   o_rdata : entry at i_raddr (combinational)
module rot_req_mem
  import rot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  rot_req_t         i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output rot_req_t         o_rdata
);

  rot_req_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rot_req_queue.sv
// rot_req_queue: FIFO of (data, rotate-amount) requests feeding the 8-bit
// rotate-right barrel shifter. The head entry is presented on out_a/out_amt.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : synchronous clear of all queued requests
//   in_valid/in_ready   : producer handshake (in_ready = not full)
//   in_data/in_amt      : request payload
//   out_valid/out_ready : consumer handshake (out_valid = not empty)
//   out_a/out_amt       : head request, forced to 0 while empty
//   count               : current occupancy
//   stat_accepted/stat_stall : saturating push / stall counters, present only
//                              when ROT_REQ_QUEUE_STATS_EN is defined
module rot_req_queue
  import rot_pkg::rot_req_t;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = rot_pkg::DATA_W,
  parameter int AMT_W  = rot_pkg::AMT_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [AMT_W-1:0]  out_amt,
  output logic [CNT_W-1:0]  count
`ifdef ROT_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]       stat_accepted,
  output logic [15:0]       stat_stall
`endif
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic     w_full;
  logic     w_empty;
  logic     w_push;
  logic     w_pop;
  rot_req_t w_wdata;
  rot_req_t w_rdata;

  // Full/empty come from the occupancy count only, so in_ready never depends
  // on out_ready and pointer equality is never ambiguous.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  assign w_wdata = '{data: in_data, amt: in_amt};

  rot_req_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push && rst_n && !flush),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_a     = w_empty ? '0 : w_rdata.data;
  assign out_amt   = w_empty ? '0 : w_rdata.amt;
  assign count     = r_count;

`ifdef ROT_REQ_QUEUE_STATS_EN
  logic [15:0] r_stat_accepted;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_stat_accepted <= '0;
      r_stat_stall    <= '0;
    end else begin
      if (w_push && (r_stat_accepted != '1)) r_stat_accepted <= r_stat_accepted + 1'b1;
      if (in_valid && w_full && (r_stat_stall != '1)) r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_accepted = r_stat_accepted;
  assign stat_stall    = r_stat_stall;
`endif

endmodule

// File: tb/tb_rot_req_queue.sv
module tb_rot_req_queue;
  import rot_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [AMT_W-1:0]  out_amt;
  logic [CNT_W-1:0]  count;
`ifdef ROT_REQ_QUEUE_STATS_EN
  logic [15:0]       stat_accepted;
  logic [15:0]       stat_stall;
  int unsigned       m_acc;
  int unsigned       m_stall;
`endif

  rot_req_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_amt   (out_amt),
    .count     (count)
`ifdef ROT_REQ_QUEUE_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_stall    (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  rot_req_t    sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge; leaves at the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_amt = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
`ifdef ROT_REQ_QUEUE_STATS_EN
    m_acc = 0; m_stall = 0;
    check("rst_stat_acc", 32'(stat_accepted), 32'd0);
    check("rst_stat_stall", 32'(stat_stall), 32'd0);
`endif
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_out_amt", 32'(out_amt), 32'd0);
  endtask

  // One clock cycle: drive inputs, check the current state against the model,
  // advance the model as the queue should, then step to the next falling edge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic [2:0] a,
                       input logic ordy, input logic fl);
    int unsigned sz;
    rot_req_t    req;
    in_valid = iv; in_data = d; in_amt = a; out_ready = ordy; flush = fl;
    sz = sb.size();
    check("count", 32'(count), 32'(sz));
    check("out_valid", 32'(out_valid), 32'(sz != 0));
    check("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    if (sz != 0) begin
      check("out_a", 32'(out_a), 32'(sb[0].data));
      check("out_amt", 32'(out_amt), 32'(sb[0].amt));
    end else begin
      check("out_a_empty", 32'(out_a), 32'd0);
      check("out_amt_empty", 32'(out_amt), 32'd0);
    end
`ifdef ROT_REQ_QUEUE_STATS_EN
    check("stat_acc", 32'(stat_accepted), m_acc);
    check("stat_stall", 32'(stat_stall), m_stall);
`endif
    if (fl) begin
      sb.delete();
`ifdef ROT_REQ_QUEUE_STATS_EN
      m_acc = 0; m_stall = 0;
`endif
    end else begin
`ifdef ROT_REQ_QUEUE_STATS_EN
      if (iv && sz != DEPTH && m_acc != 16'hFFFF) m_acc++;
      if (iv && sz == DEPTH && m_stall != 16'hFFFF) m_stall++;
`endif
      if (ordy && sz != 0) void'(sb.pop_front());
      if (iv && sz != DEPTH) begin
        req.data = d;
        req.amt  = a;
        sb.push_back(req);
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_amt = '0;
    @(negedge clk);
    do_reset();

    // Single push, held across idle cycles.
    cycle(1'b1, 8'hB4, 3'd3, 1'b0, 1'b0);
    check("single_out_a", 32'(out_a), 32'hB4);
    check("single_out_amt", 32'(out_amt), 32'd3);
    for (int k = 0; k < 5; k++) cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    drain(2);

    // Fill to full, fifth push dropped, drain in order.
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'(k + 1), 3'(k), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 8'h05, 3'd4, 1'b0, 1'b0);
    drain(5);
    check("drained_out_a", 32'(out_a), 32'd0);

    // Full with simultaneous push and pop: only the pop happens.
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'(8'h10 + k), 3'(k + 4), 1'b0, 1'b0);
    cycle(1'b1, 8'h99, 3'd7, 1'b1, 1'b0);
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_in_ready", 32'(in_ready), 32'd1);
    drain(4);

    // Streaming across pointer wrap.
    cycle(1'b1, 8'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) cycle(1'b1, 8'(i), 3'(i % 8), 1'b1, 1'b0);
    check("stream_count", 32'(count), 32'd1);
    drain(2);

    // Flush with three queued and a push offered in the flush cycle.
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'hA0 + k), 3'(k), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 3'd5, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);

    // Reset mid-operation drops queued requests.
    cycle(1'b1, 8'h5A, 3'd1, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);

`ifdef ROT_REQ_QUEUE_STATS_EN
    for (int k = 0; k < 6; k++) cycle(1'b1, 8'(8'h30 + k), 3'(k), 1'b0, 1'b0);
    check("stats_accepted", 32'(stat_accepted), 32'd4);
    check("stats_stall", 32'(stat_stall), 32'd2);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
